booth_seq_acc16: RTL and testbench

Sequential radix-4 Booth controller and accumulator for 16x16 signed multiplication. It accepts a multiplicand/multiplier pair over a valid/ready handshake and walks the multiplier one Booth triplet per cycle. Each triplet and the held multiplicand are driven to an external combinational Booth partial-product encoder. The signed partial product that comes back is shifted and accumulated into a 32-bit product, which is returned over a second valid/ready handshake. It is the consuming end of the partial-product encoder interface in the mul_16_16 datapath.

---
 rtl/booth_seq_acc16.sv | 149 ++++++++++++++
 tb/tb_booth_seq_acc16.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_seq_acc16.sv
// booth_seq_acc16
// Sequential radix-4 Booth controller and accumulator for signed 16x16 -> 32
// multiplication. One Booth triplet is presented to an external combinational
// partial-product encoder per cycle. The signed partial product that comes
// back is shifted into place and summed into a 32-bit accumulator. The
// finished product is held on a valid/ready output until it is taken.

module booth_seq_acc16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_x,
  input  logic [15:0] in_y,
  output logic [15:0] booth_x,
  output logic [2:0]  booth_sel,
  input  logic [17:0] booth_pp,
  output logic        busy,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_prod
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [15:0] x_reg;
  logic [15:0] y_reg;
  logic [31:0] acc;
  logic [2:0]  cnt;

  logic        accept;
  logic        deliver;
  logic        last_step;

  // Multiplier with the implicit y[-1]=0 appended below bit 0, so that
  // triplet i is simply bits [2i+2:2i] of this vector.
  logic [16:0] y_ext;
  logic [4:0]  sel_base;

  // Partial product sign-extended to 32 bits and its weight-aligned copy.
  logic [31:0] pp_ext;
  logic [31:0] pp_aligned;

  // Handshake and sequencing qualifiers.
  always_comb begin
    accept    = (state == IDLE) && in_valid;
    deliver   = (state == DONE) && out_ready;
    last_step = (state == RUN) && (cnt == 3'd7);
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (accept) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_step) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (deliver) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand registers: captured only on the accept edge, held otherwise so
  // that operands presented while running are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_reg <= 16'd0;
      y_reg <= 16'd0;
    end else if (accept) begin
      x_reg <= in_x;
      y_reg <= in_y;
    end
  end

  // Triplet selection, derived purely from registered state.
  always_comb begin
    y_ext     = {y_reg, 1'b0};
    sel_base  = {1'b0, cnt, 1'b0};
    booth_sel = 3'b000;
    if (state == RUN) begin
      booth_sel = y_ext[sel_base +: 3];
    end
  end

  // Sign-extend the encoder result and move it to weight 4^cnt.
  always_comb begin
    pp_ext     = {{14{booth_pp[17]}}, booth_pp};
    pp_aligned = pp_ext << sel_base;
  end

  // Accumulator and triplet counter: cleared on accept, one step per RUN
  // cycle. The count stops at 7 because the FSM leaves RUN on that edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= 32'd0;
      cnt <= 3'd0;
    end else if (accept) begin
      acc <= 32'd0;
      cnt <= 3'd0;
    end else if (state == RUN) begin
      acc <= acc + pp_aligned;
      if (!last_step) begin
        cnt <= cnt + 3'd1;
      end
    end
  end

  // Encoder multiplicand and product come straight from registers.
  always_comb begin
    booth_x  = x_reg;
    out_prod = acc;
  end

endmodule

// File: tb/tb_booth_seq_acc16.sv
// tb_booth_seq_acc16
// Directed and randomised bench for booth_seq_acc16. The external Booth
// encoder is modelled here; a transaction-level reference tracks the expected
// handshake timing and product and is compared against the DUT every cycle.

module tb_booth_seq_acc16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_x = 16'd0;
  logic [15:0] in_y = 16'd0;
  logic [15:0] booth_x;
  logic [2:0]  booth_sel;
  logic [17:0] booth_pp;
  logic        busy;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_prod;

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  int ready_mode = 1;
  int accept_cycle = 0;
  int hs_count = 0;
  logic [2:0] sel_log[$];
  int accept_log[$];

  // Reference state: phase 0 idle, 1..8 the eight busy cycles, 9 product held.
  int          m_phase = 0;
  logic [15:0] m_x = 16'd0;
  logic [15:0] m_y = 16'd0;
  logic [31:0] m_prod = 32'd0;

  booth_seq_acc16 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .booth_x   (booth_x),
    .booth_sel (booth_sel),
    .booth_pp  (booth_pp),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prod  (out_prod)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    int ia;
    int ib;
    ia = $signed(a);
    ib = $signed(b);
    return 32'(ia * ib);
  endfunction

  function automatic logic [17:0] enc_model(input logic [15:0] x, input logic [2:0] s);
    int d;
    int p;
    case (s)
      3'b001, 3'b010: d = 1;
      3'b011:         d = 2;
      3'b100:         d = -2;
      3'b101, 3'b110: d = -1;
      default:        d = 0;
    endcase
    p = $signed(x);
    p = p * d;
    return 18'(p);
  endfunction

  function automatic logic [2:0] exp_sel(input logic [15:0] y, input int i);
    logic lo;
    lo = 1'b0;
    if (i > 0) lo = y[2*i-1];
    return {y[2*i+1], y[2*i], lo};
  endfunction

  assign booth_pp = enc_model(booth_x, booth_sel);

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cycle <= cycle + 1;

  // Output-ready driver: 0 = held low, 1 = held high, 2 = random.
  initial forever begin
    @(posedge clk);
    #1;
    if (ready_mode == 2) out_ready = 1'($urandom_range(0, 1));
    else out_ready = (ready_mode == 1);
  end

  // Transaction-level reference for handshake timing and product value.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_x     <= 16'd0;
      m_y     <= 16'd0;
      m_prod  <= 32'd0;
    end else if (m_phase == 0) begin
      if (in_valid) begin
        m_phase <= 1;
        m_x     <= in_x;
        m_y     <= in_y;
        m_prod  <= ref_mul(in_x, in_y);
      end
    end else if (m_phase < 9) begin
      m_phase <= m_phase + 1;
    end else if (out_ready) begin
      m_phase <= 0;
    end
  end

  // Per-cycle comparison against the reference, plus event logging.
  always @(negedge clk) begin
    check_output("in_ready", 32'(in_ready), 32'(m_phase == 0));
    check_output("busy", 32'(busy), 32'(m_phase >= 1 && m_phase <= 8));
    check_output("out_valid", 32'(out_valid), 32'(m_phase == 9));
    check_output("booth_x", 32'(booth_x), 32'(m_x));
    if (m_phase >= 1 && m_phase <= 8)
      check_output("booth_sel", 32'(booth_sel), 32'(exp_sel(m_y, m_phase - 1)));
    else
      check_output("booth_sel_idle", 32'(booth_sel), 32'd0);
    if (m_phase == 9) check_output("out_prod", out_prod, m_prod);
    if (busy) sel_log.push_back(booth_sel);
    if (in_valid && in_ready) accept_log.push_back(cycle + 1);
    if (out_valid && out_ready) hs_count++;
  end

  task automatic apply_stimulus(input logic [15:0] x, input logic [15:0] y);
    logic rdy;
    int n;
    rdy = 1'b0;
    n = 0;
    in_x = x;
    in_y = y;
    in_valid = 1'b1;
    while (!rdy && n < 50) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      n++;
    end
    #1;
    in_valid = 1'b0;
    accept_cycle = cycle;
    if (!rdy) check_output("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_product(output logic [31:0] prod);
    logic got;
    int n;
    got = 1'b0;
    n = 0;
    prod = 32'd0;
    while (!got && n < 200) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        got = 1'b1;
        prod = out_prod;
      end
      @(posedge clk);
      n++;
    end
    #1;
    if (!got) check_output("product_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check_output({tag, "_busy"}, 32'(busy), 32'd0);
    check_output({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check_output({tag, "_out_prod"}, out_prod, 32'd0);
    check_output({tag, "_booth_sel"}, 32'(booth_sel), 32'd0);
    check_output({tag, "_booth_x"}, 32'(booth_x), 32'd0);
  endtask

  initial begin
    logic [31:0] prod;
    logic [2:0]  exp_seq[8];
    int n;
    logic [15:0] rx;
    logic [15:0] ry;

    // Power-on reset.
    #1 rst_n = 1'b0;
    #2 check_reset_outputs("por");
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // 3 * 5: triplet sequence, latency and handshake timing.
    $display("[TB] directed 3*5");
    ready_mode = 1;
    sel_log.delete();
    apply_stimulus(16'd3, 16'd5);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_output("latency_3x5", 32'(cycle - accept_cycle), 32'd8);
    check_output("prod_3x5", out_prod, 32'h0000000F);
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_output("handshake_3x5", 32'(cycle - accept_cycle), 32'd9);
    exp_seq = '{3'b010, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    check_output("sel_count_3x5", 32'(sel_log.size()), 32'd8);
    for (int i = 0; i < 8 && i < sel_log.size(); i++)
      check_output("sel_seq_3x5", 32'(sel_log[i]), 32'(exp_seq[i]));
    @(posedge clk);
    #1;

    // Extremes.
    $display("[TB] extremes");
    apply_stimulus(16'h8000, 16'h8000);
    wait_product(prod);
    check_output("prod_min_min", prod, 32'h40000000);
    apply_stimulus(16'hFFFF, 16'h0001);
    wait_product(prod);
    check_output("prod_m1_p1", prod, 32'hFFFFFFFF);
    ready_mode = 0;
    apply_stimulus(16'h7FFF, 16'h8000);
    repeat (25) @(posedge clk);
    #1;
    ready_mode = 1;
    wait_product(prod);
    check_output("prod_max_min_stalled", prod, 32'hC0008000);

    // Random pairs with random backpressure.
    $display("[TB] random pairs");
    ready_mode = 2;
    for (int k = 0; k < 1000; k++) begin
      rx = 16'($urandom);
      ry = 16'($urandom);
      apply_stimulus(rx, ry);
      wait_product(prod);
      check_output("prod_random", prod, ref_mul(rx, ry));
    end
    ready_mode = 1;
    repeat (3) @(posedge clk);
    #1;

    // in_valid held high, operands changing every cycle.
    $display("[TB] continuous in_valid");
    accept_log.delete();
    hs_count = 0;
    in_valid = 1'b1;
    repeat (60) begin
      in_x = 16'($urandom);
      in_y = 16'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    check_output("cont_accepts_ge5", 32'(accept_log.size() >= 5), 32'd1);
    check_output("cont_one_accept_per_product", 32'(accept_log.size()), 32'(hs_count));
    for (int i = 1; i < accept_log.size(); i++)
      check_output("cont_spacing", 32'(accept_log[i] - accept_log[i-1]), 32'd10);

    // Reset mid-operation, then a clean operation.
    $display("[TB] reset mid-operation");
    apply_stimulus(16'd1234, 16'hFDC9);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    apply_stimulus(16'd7, 16'hFFF7);
    wait_product(prod);
    check_output("prod_after_reset", prod, 32'hFFFFFFC1);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
